id_ex_pipe_reg: RTL

//   ID->EX pipeline register downstream of the register file; consumes RD1/RD2 and the decoded fields.

---
 rtl/id_ex_pipe_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/id_ex_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_pipe_reg
//  Purpose  : ID->EX pipeline register. Captures register-file operands and
//             decoded fields, detects load-use hazards, inserts bubbles,
//             honours stall/flush and counts inserted bubbles (saturating).
//  Options  : WB_BYPASS_EN - when defined, a same-cycle writeback to rs/rt
//             overrides the register-file read data captured into EX.
//  Revision : 1.0 - initial release
// ============================================================================
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_ReadReg1,
  input  logic [ADDR_W-1:0] id_ReadReg2,
  input  logic              id_uses_rt,
  input  logic [ADDR_W-1:0] id_WriteReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic              wb_RegWrite,
  input  logic [ADDR_W-1:0] wb_WriteReg,
  input  logic [DATA_W-1:0] wb_WriteData,
  output logic              hazard_stall,
  output logic              ex_valid,
  output logic [DATA_W-1:0] ex_RD1,
  output logic [DATA_W-1:0] ex_RD2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [ADDR_W-1:0] ex_ReadReg1,
  output logic [ADDR_W-1:0] ex_ReadReg2,
  output logic [ADDR_W-1:0] ex_WriteReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              bubble;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  // Load in EX whose destination (non-zero) is read by the instruction in ID
  always_comb begin
    hazard_stall = id_valid & ex_valid & ex_MemRead & (ex_WriteReg != '0) &
                   ((ex_WriteReg == id_ReadReg1) |
                    (id_uses_rt & (ex_WriteReg == id_ReadReg2)));
  end

  // A bubble is inserted on flush or hazard unless stall freezes EX
  assign bubble = ~stall & (flush | hazard_stall);

`ifdef WB_BYPASS_EN
  // Forward a same-cycle writeback over stale register-file data (never index 0)
  always_comb begin
    op1 = id_rd1;
    op2 = id_rd2;
    if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == id_ReadReg1))
      op1 = wb_WriteData;
    if (wb_RegWrite && (wb_WriteReg != '0) && (wb_WriteReg == id_ReadReg2))
      op2 = wb_WriteData;
  end
`else
  // Writeback port is not consumed without the bypass
  logic unused_wb;
  assign unused_wb = ^{wb_RegWrite, wb_WriteReg, wb_WriteData};

  // Operands come straight from the register file
  always_comb begin
    op1 = id_rd1;
    op2 = id_rd2;
  end
`endif

  // EX stage register: stall holds, bubble clears, otherwise capture ID
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_RD1      <= '0;
      ex_RD2      <= '0;
      ex_imm      <= '0;
      ex_ReadReg1 <= '0;
      ex_ReadReg2 <= '0;
      ex_WriteReg <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
    end else if (stall) begin
      ex_valid    <= ex_valid;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_RD1      <= '0;
      ex_RD2      <= '0;
      ex_imm      <= '0;
      ex_ReadReg1 <= '0;
      ex_ReadReg2 <= '0;
      ex_WriteReg <= '0;
      ex_RegWrite <= 1'b0;
      ex_MemRead  <= 1'b0;
    end else begin
      ex_valid    <= id_valid;
      ex_RD1      <= op1;
      ex_RD2      <= op2;
      ex_imm      <= id_imm;
      ex_ReadReg1 <= id_ReadReg1;
      ex_ReadReg2 <= id_ReadReg2;
      ex_WriteReg <= id_WriteReg;
      ex_RegWrite <= id_RegWrite & id_valid;
      ex_MemRead  <= id_MemRead & id_valid;
    end
  end

  // Saturating count of inserted bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      bubble_cnt <= '0;
    else if (bubble && (bubble_cnt != CNT_MAX))
      bubble_cnt <= bubble_cnt + 1'b1;
  end

endmodule
`default_nettype wire
